// File: rtl/stopwatch_pkg.sv
// Shared types, digit limits and the BCD increment helper for the stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, FULL} sw_state_t;

    localparam logic [3:0]  TENTHS_MAX  = 4'd9;
    localparam logic [3:0]  SEC1_MAX    = 4'd9;
    localparam logic [3:0]  SEC10_MAX   = 4'd5;
    localparam logic [3:0]  MIN_MAX     = 4'd9;
    localparam logic [15:0] FULL_DIGITS = 16'h9599;

    // Add one tenth to an M:SS.t BCD value with cascaded carries.
    // Minutes saturate at MIN_MAX; the FSM never asks for more than that.
    function automatic logic [15:0] bcd_inc(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        if (d[3:0] != TENTHS_MAX) begin
            r[3:0] = d[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (d[7:4] != SEC1_MAX) begin
                r[7:4] = d[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (d[11:8] != SEC10_MAX) begin
                    r[11:8] = d[11:8] + 4'd1;
                end else begin
                    r[11:8] = 4'd0;
                    if (d[15:12] != MIN_MAX)
                        r[15:12] = d[15:12] + 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_core_sw_sync_edge.sv
// Optional synchroniser followed by a rising-edge detector (one-cycle pulse).
// With SYNC_STAGES=0 the input is only registered once before edge detection,
// for inputs that are already synchronous to clk.
module sw_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);
    // The last synchroniser flop doubles as the edge detector's current
    // sample, so a synchronised button adds no extra latency to the pulse.
    localparam int LEN = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;

    logic [LEN:0] sr;

    // Shift the input through the synchroniser and one delay flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= '0;
        else     sr <= {sr[LEN-1:0], din};
    end

    assign pulse = sr[LEN-1] & ~sr[LEN];

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timing core: button/tick conditioning, prescaler, BCD chain, FSM.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_COUNT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_in,
    input  logic        btn_ss,
    input  logic        btn_clr,
    output logic [15:0] digits,
    output logic        running,
    output logic        overflow
);
    localparam logic [9:0] PRESC_TC = 10'(TICKS_PER_COUNT - 1);

    sw_state_t  state, next_state;
    logic [9:0] presc;
    logic       ss_p, clr_p, tick_p, inc;

    sw_sync_edge #(.SYNC_STAGES(2)) u_ss (
        .clk(clk), .rst(rst), .din(btn_ss), .pulse(ss_p)
    );

    sw_sync_edge #(.SYNC_STAGES(2)) u_clr (
        .clk(clk), .rst(rst), .din(btn_clr), .pulse(clr_p)
    );

    // tick_in is already synchronous; only the edge stage is used.
    sw_sync_edge #(.SYNC_STAGES(0)) u_tick (
        .clk(clk), .rst(rst), .din(tick_in), .pulse(tick_p)
    );

    assign inc = (state == RUN) && tick_p && (presc == PRESC_TC);

    // Next-state logic; clear overrides everything, reaching 9:59.9 beats start/stop.
    always_comb begin
        next_state = state;
        if (clr_p) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (ss_p) next_state = RUN;
                RUN: begin
                    if (inc && digits == FULL_DIGITS) next_state = FULL;
                    else if (ss_p)                    next_state = PAUSE;
                end
                PAUSE:   if (ss_p) next_state = RUN;
                FULL:    next_state = FULL;
                default: next_state = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Prescaler: counts ticks only while running, zero whenever idle or cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            presc <= '0;
        else if (clr_p || state == IDLE)
            presc <= '0;
        else if (state == RUN && tick_p)
            presc <= (presc == PRESC_TC) ? 10'd0 : presc + 10'd1;
    end

    // BCD digit chain; frozen outside RUN and held at 9:59.9 on the overflowing tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            digits <= '0;
        else if (clr_p || state == IDLE)
            digits <= '0;
        else if (inc && digits != FULL_DIGITS)
            digits <= bcd_inc(digits);
    end

    assign running  = (state == RUN);
    assign overflow = (state == FULL);

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench: two cores (1 and 4 ticks per count) share one stimulus stream.
module tb_stopwatch_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_in = 1'b0;
    logic        btn_ss = 1'b0;
    logic        btn_clr = 1'b0;
    logic [15:0] d1, d4;
    logic        r1, r4, o1, o4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stopwatch_core #(.TICKS_PER_COUNT(1)) dut1 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .btn_ss(btn_ss),
        .btn_clr(btn_clr), .digits(d1), .running(r1), .overflow(o1)
    );

    stopwatch_core #(.TICKS_PER_COUNT(4)) dut4 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .btn_ss(btn_ss),
        .btn_clr(btn_clr), .digits(d4), .running(r4), .overflow(o4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick_in = 1'b1;
            @(negedge clk) tick_in = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic press_ss();
        @(negedge clk) btn_ss = 1'b1;
        repeat (3) @(negedge clk);
        btn_ss = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press_clr();
        @(negedge clk) btn_clr = 1'b1;
        repeat (3) @(negedge clk);
        btn_clr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int   toggles;
        logic prev;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_digits", {16'h0, d1}, 32'h0000);
        chk("rst_running", {31'h0, r1}, 32'h0);
        chk("rst_overflow", {31'h0, o1}, 32'h0);

        // Ticks while idle do nothing.
        ticks(15);
        chk("idle_digits", {16'h0, d1}, 32'h0000);
        chk("idle_running", {31'h0, r1}, 32'h0);

        // Start, 123 ticks.
        press_ss();
        chk("start_running", {31'h0, r1}, 32'h1);
        ticks(123);
        chk("run123_d1", {16'h0, d1}, 32'h0123);
        chk("run123_d4", {16'h0, d4}, 32'h0030);
        chk("run123_running", {31'h0, r1}, 32'h1);

        // Pause, 50 ticks frozen.
        press_ss();
        ticks(50);
        chk("pause_d1", {16'h0, d1}, 32'h0123);
        chk("pause_d4", {16'h0, d4}, 32'h0030);
        chk("pause_running", {31'h0, r1}, 32'h0);

        // Clear from pause, then prescaler remainder across a pause.
        press_clr();
        chk("clr_d1", {16'h0, d1}, 32'h0000);
        chk("clr_d4", {16'h0, d4}, 32'h0000);
        press_ss();
        ticks(10);
        chk("presc10_d4", {16'h0, d4}, 32'h0002);
        chk("presc10_d1", {16'h0, d1}, 32'h0010);
        press_ss();
        press_ss();
        ticks(2);
        chk("presc_resume_d4", {16'h0, d4}, 32'h0003);
        chk("presc_resume_d1", {16'h0, d1}, 32'h0012);

        // Carry chain and overflow.
        press_clr();
        press_ss();
        ticks(599);
        chk("c599_d1", {16'h0, d1}, 32'h0599);
        chk("c599_d4", {16'h0, d4}, 32'h0149);
        ticks(1);
        chk("c600_d1", {16'h0, d1}, 32'h1000);
        chk("c600_d4", {16'h0, d4}, 32'h0150);
        ticks(5399);
        chk("max_d1", {16'h0, d1}, 32'h9599);
        chk("max_overflow", {31'h0, o1}, 32'h0);
        ticks(1);
        chk("full_d1", {16'h0, d1}, 32'h9599);
        chk("full_overflow", {31'h0, o1}, 32'h1);
        chk("full_running", {31'h0, r1}, 32'h0);
        ticks(3);
        press_ss();
        chk("full_hold_d1", {16'h0, d1}, 32'h9599);
        chk("full_hold_overflow", {31'h0, o1}, 32'h1);
        chk("full_hold_running", {31'h0, r1}, 32'h0);

        // Clear and start/stop together: clear wins.
        press_clr();
        chk("full_clr_overflow", {31'h0, o1}, 32'h0);
        press_ss();
        ticks(34);
        chk("run34_d1", {16'h0, d1}, 32'h0034);
        @(negedge clk) begin btn_ss = 1'b1; btn_clr = 1'b1; end
        repeat (3) @(negedge clk);
        btn_ss = 1'b0;
        btn_clr = 1'b0;
        repeat (4) @(negedge clk);
        chk("both_d1", {16'h0, d1}, 32'h0000);
        chk("both_running", {31'h0, r1}, 32'h0);

        // Asynchronous reset mid-cycle while running.
        press_ss();
        ticks(50);
        chk("run50_d1", {16'h0, d1}, 32'h0050);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_digits", {16'h0, d1}, 32'h0000);
        chk("async_rst_running", {31'h0, r1}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Holding start/stop yields a single toggle.
        @(negedge clk) btn_ss = 1'b1;
        toggles = 0;
        prev = r1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (r1 !== prev) toggles++;
            prev = r1;
        end
        btn_ss = 1'b0;
        chk("hold_toggles", 32'(toggles), 32'd1);
        chk("hold_running", {31'h0, r1}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
